// File: rtl/rv32imf_obi_mem_responder.sv
// OBI responder backed by a word-organised memory. Grants are limited by an outstanding
// counter, and responses come back in order through a fixed-latency shift register.
module rv32imf_obi_mem_responder #(
    parameter int DEPTH           = 1024,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    input  logic [5:0]  obi_atop_i,
    output logic [31:0] obi_rdata_o,
    output logic        obi_rvalid_o,
    output logic        obi_err_o,
    input  logic        stall_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
    localparam logic [32:0]   ADDR_LIMIT = 33'(DEPTH) << 2;

    logic [31:0]   mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;
    logic          accept, req_err;
    logic [31:0]   rsp_data;

    logic [LATENCY:1]       vld_pipe;
    logic [LATENCY:1]       err_pipe;
    logic [LATENCY:1][31:0] rdata_pipe;

    assign obi_gnt_o = obi_req_i & ~stall_i & (cnt < MAX_CNT);
    assign accept    = obi_req_i & obi_gnt_o;
    assign idx       = obi_addr_i[AW+1:2];
    assign req_err   = ({1'b0, obi_addr_i} >= ADDR_LIMIT) | (obi_atop_i != 6'd0);

    // Read data is sampled from the pre-write array, so a same-edge write is not visible.
    assign rsp_data  = (accept & ~req_err & ~obi_we_i) ? mem[idx] : 32'd0;

    // Memory contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept && obi_we_i && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (obi_be_i[b]) mem[idx][b*8 +: 8] <= obi_wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            err_pipe   <= '0;
            rdata_pipe <= '0;
        end else begin
            vld_pipe[1]   <= accept;
            err_pipe[1]   <= accept & req_err;
            rdata_pipe[1] <= rsp_data;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe[i]   <= vld_pipe[i-1];
                err_pipe[i]   <= err_pipe[i-1];
                rdata_pipe[i] <= rdata_pipe[i-1];
            end
        end
    end

    assign obi_rvalid_o = vld_pipe[LATENCY];
    assign obi_err_o    = err_pipe[LATENCY];
    assign obi_rdata_o  = rdata_pipe[LATENCY];

    // A slot freed by rvalid only becomes grantable on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({accept, obi_rvalid_o})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32imf_obi_mem_responder.sv
// Directed bench for the OBI memory responder. Expected responses are queued when a grant is
// observed, and are checked for data, error and arrival cycle when rvalid appears.
module tb_rv32imf_obi_mem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, gnt, we, rvalid, err, stall;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic [5:0]  atop;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q[$];

    rv32imf_obi_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr),
        .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_atop_i(atop),
        .obi_rdata_o(rdata), .obi_rvalid_o(rvalid), .obi_err_o(err), .stall_i(stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        x.cyc   = cyc + LAT;
        q.push_back(x);
    endtask

    // Scoreboard: every rvalid must match the oldest queued expectation, in the right cycle.
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (q.size() == 0) begin
                chk("unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("rsp_rdata", rdata, x.rdata);
                chk("rsp_err", 32'(err), 32'(x.err));
                chk("rsp_cycle", 32'(cyc), 32'(x.cyc));
            end
        end
    end

    task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [5:0] at,
                        input logic [31:0] exp_d, input logic exp_e);
        int n;
        req = 1'b1; we = w; addr = a; be = b; wdata = d; atop = at;
        n = 0;
        @(negedge clk);
        while (!gnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_timeout", 32'(gnt), 32'd1);
        if (gnt) push(exp_d, exp_e);
        @(posedge clk);
        #1;
        req = 1'b0; addr = $urandom; wdata = $urandom; we = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_g5[5];
        logic exp_v5[5];
        logic exp_g3[3];
        exp_g5 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_v5 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_g3 = '{1'b1, 1'b1, 1'b0};

        // T1: reset held with a request pending; the request is the T2 write.
        rst_n = 1'b0; stall = 1'b0;
        req = 1'b1; we = 1'b1; addr = 32'h10; be = 4'hF; wdata = 32'hDEADBEEF; atop = 6'd0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rvalid", 32'(rvalid), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_err", 32'(err), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("gnt_after_reset", 32'(gnt), 32'd1);
        if (gnt) push(32'd0, 1'b0);
        @(posedge clk);
        #1 req = 1'b0;

        // T2: read back the full word.
        xact(1'b0, 32'h10, 4'hF, 32'd0, 6'd0, 32'hDEADBEEF, 1'b0);
        // T3: partial write, then a back-to-back read of the same word.
        xact(1'b1, 32'h10, 4'b0101, 32'h11223344, 6'd0, 32'd0, 1'b0);
        xact(1'b0, 32'h13, 4'b0000, 32'd0, 6'd0, 32'hDE22BE44, 1'b0);
        // be=0000 write is a no-op.
        xact(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 6'd0, 32'd0, 1'b0);
        // T4: out-of-range read, atomic write, and the last valid word.
        xact(1'b0, 32'(4 * DEPTH), 4'hF, 32'd0, 6'd0, 32'd0, 1'b1);
        xact(1'b1, 32'h10, 4'hF, 32'hFFFFFFFF, 6'h01, 32'd0, 1'b1);
        xact(1'b1, 32'(4 * DEPTH - 4), 4'hF, 32'hA5A55A5A, 6'd0, 32'd0, 1'b0);
        xact(1'b0, 32'(4 * DEPTH - 4), 4'hF, 32'd0, 6'd0, 32'hA5A55A5A, 1'b0);
        xact(1'b0, 32'h10, 4'hF, 32'd0, 6'd0, 32'hDE22BE44, 1'b0);
        drain();

        // T5: outstanding limit with the request held high.
        req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'hF; atop = 6'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("limit_gnt_c%0d", k), 32'(gnt), 32'(exp_g5[k]));
            chk($sformatf("limit_rvalid_c%0d", k), 32'(rvalid), 32'(exp_v5[k]));
            if (gnt) push(32'hDE22BE44, 1'b0);
        end
        @(posedge clk);
        #1 req = 1'b0;
        drain();

        // T6: stalled write must neither be granted nor touch memory.
        req = 1'b1; we = 1'b1; addr = 32'h10; be = 4'hF; wdata = 32'h0; stall = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_gnt", 32'(gnt), 32'd0);
        end
        @(posedge clk);
        #1 begin req = 1'b0; stall = 1'b0; end
        xact(1'b0, 32'h10, 4'hF, 32'd0, 6'd0, 32'hDE22BE44, 1'b0);
        drain();

        // Reset while a read is in flight: it must be dropped and the counter cleared.
        req = 1'b1; we = 1'b0; addr = 32'h10;
        @(negedge clk);
        chk("pre_reset_gnt", 32'(gnt), 32'd1);
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1 begin rst_n = 1'b0; q.delete(); end
        repeat (2) begin
            @(negedge clk);
            chk("midreset_rvalid", 32'(rvalid), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_reset_rvalid", 32'(rvalid), 32'd0);
        end
        @(posedge clk);
        #1 req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset_gnt_c%0d", k), 32'(gnt), 32'(exp_g3[k]));
            if (gnt) push(32'hDE22BE44, 1'b0);
        end
        @(posedge clk);
        #1 req = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
